// File: rtl/fetch_unit.sv
// Instruction fetch responder: samples PCaddr, reads one word from memory,
// returns it with a one-cycle iready pulse; misaligned PCs park in FAULT.
module fetch_unit (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] PCaddr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  output logic [31:0] instr,
  output logic        iready,
  output logic        ifault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    RESP,
    FAULT
  } state_t;

  state_t state;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= REQ;
      mem_ren     <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      iready      <= 1'b0;
      ifault      <= 1'b0;
      fetch_count <= '0;
    end else begin
      unique case (state)
        REQ: begin
          if (PCaddr[1:0] != 2'b00) begin
            ifault  <= 1'b1;
            mem_ren <= 1'b0;
            state   <= FAULT;
          end else begin
            mem_addr <= PCaddr;
            mem_ren  <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!mem_busy) begin
            instr       <= mem_rdata;
            iready      <= 1'b1;
            mem_ren     <= 1'b0;
            fetch_count <= fetch_count + 32'd1;
            state       <= RESP;
          end
        end
        RESP: begin
          iready <= 1'b0;
          state  <= REQ;
        end
        FAULT: begin
          // Terminal until reset; only the fault flag is asserted.
          ifault  <= 1'b1;
          mem_ren <= 1'b0;
          iready  <= 1'b0;
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a per-fetch transaction model
// that predicts bus address, data, iready timing and fetch counts.
module tb_fetch_unit;

  logic        clk;
  logic        nRST;
  logic [31:0] PCaddr;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] instr;
  logic        iready;
  logic        ifault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_count;
  logic [31:0] exp_instr;
  logic [31:0] exp_addr;

  fetch_unit dut (
    .clk         (clk),
    .nRST        (nRST),
    .PCaddr      (PCaddr),
    .mem_rdata   (mem_rdata),
    .mem_busy    (mem_busy),
    .mem_ren     (mem_ren),
    .mem_addr    (mem_addr),
    .instr       (instr),
    .iready      (iready),
    .ifault      (ifault),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".ren"}, {31'd0, mem_ren}, 32'd0);
    check({tag, ".addr"}, mem_addr, 32'd0);
    check({tag, ".instr"}, instr, 32'd0);
    check({tag, ".iready"}, {31'd0, iready}, 32'd0);
    check({tag, ".ifault"}, {31'd0, ifault}, 32'd0);
    check({tag, ".count"}, fetch_count, 32'd0);
  endtask

  // One complete fetch starting at a REQ edge; entered and left at negedge.
  task automatic fetch(input logic [31:0] pc,
                       input logic [31:0] data,
                       input int          nbusy);
    PCaddr    = pc;
    mem_busy  = 1'($urandom);
    mem_rdata = $urandom;
    step();
    exp_addr = pc;
    check("req.ren", {31'd0, mem_ren}, 32'd1);
    check("req.addr", mem_addr, exp_addr);
    check("req.iready", {31'd0, iready}, 32'd0);
    check("req.instr", instr, exp_instr);
    for (int i = 0; i < nbusy; i++) begin
      mem_busy  = 1'b1;
      mem_rdata = $urandom;
      PCaddr    = $urandom;
      step();
      check("wait.ren", {31'd0, mem_ren}, 32'd1);
      check("wait.addr", mem_addr, exp_addr);
      check("wait.iready", {31'd0, iready}, 32'd0);
      check("wait.count", fetch_count, exp_count);
    end
    mem_busy  = 1'b0;
    mem_rdata = data;
    step();
    exp_instr = data;
    exp_count = exp_count + 32'd1;
    check("resp.iready", {31'd0, iready}, 32'd1);
    check("resp.instr", instr, exp_instr);
    check("resp.ren", {31'd0, mem_ren}, 32'd0);
    check("resp.count", fetch_count, exp_count);
    check("resp.addr", mem_addr, exp_addr);
    mem_busy  = 1'($urandom);
    mem_rdata = $urandom;
    PCaddr    = $urandom;
    step();
    check("post.iready", {31'd0, iready}, 32'd0);
    check("post.instr", instr, exp_instr);
    check("post.ren", {31'd0, mem_ren}, 32'd0);
    check("post.ifault", {31'd0, ifault}, 32'd0);
  endtask

  initial begin
    nRST      = 1'b1;
    PCaddr    = '0;
    mem_rdata = '0;
    mem_busy  = 1'b0;
    exp_count = '0;
    exp_instr = '0;
    exp_addr  = '0;
    #3 nRST = 1'b0;
    #1 check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    nRST = 1'b1;

    // Zero-wait first fetch, then a 3-cycle wait-state fetch
    fetch(32'h0000_0000, 32'h0000_0013, 0);
    check("first.count", fetch_count, 32'd1);
    fetch(32'h0000_0040, 32'hDEAD_BEEF, 3);

    // Sequential PC stream of 10 fetches
    exp_count = fetch_count;
    for (int i = 0; i < 10; i++)
      fetch(32'(i * 4), $urandom, 0);
    check("seq.last_addr", mem_addr, 32'h0000_0024);

    // Randomized aligned fetches with random wait states
    for (int i = 0; i < 40; i++)
      fetch({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom,
            $urandom_range(0, 3));

    // Same-address refetch is an ordinary fetch
    fetch(32'h0000_1000, 32'h1111_2222, 1);
    fetch(32'h0000_1000, 32'h3333_4444, 0);

    // Counter wrap
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1 release dut.fetch_count;
    exp_count = 32'hFFFF_FFFF;
    fetch(32'h0000_2000, 32'hCAFE_F00D, 1);
    check("wrap.count", fetch_count, 32'h0000_0000);

    // Reset mid-WAIT
    PCaddr   = 32'h0000_0300;
    mem_busy = 1'b1;
    step();
    check("midwait.ren", {31'd0, mem_ren}, 32'd1);
    #2 nRST = 1'b0;
    #1 check_reset_vals("midwait");
    exp_count = '0;
    exp_instr = '0;
    @(negedge clk);
    nRST = 1'b1;
    fetch(32'h0000_0300, 32'h0BAD_CAFE, 2);
    check("after_rst.count", fetch_count, 32'd1);

    // Misaligned fetch: sticky fault, bus quiet, PCaddr ignored
    PCaddr = 32'h0000_0102;
    step();
    check("fault.ifault", {31'd0, ifault}, 32'd1);
    check("fault.ren", {31'd0, mem_ren}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      PCaddr    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      mem_busy  = 1'($urandom);
      mem_rdata = $urandom;
      step();
      check("fault.hold_if", {31'd0, ifault}, 32'd1);
      check("fault.hold_ren", {31'd0, mem_ren}, 32'd0);
      check("fault.hold_rdy", {31'd0, iready}, 32'd0);
      check("fault.instr", instr, exp_instr);
      check("fault.addr", mem_addr, exp_addr);
      check("fault.count", fetch_count, exp_count);
    end
    nRST = 1'b0;
    #1 check_reset_vals("fault_clr");
    @(negedge clk);
    nRST = 1'b1;
    exp_count = '0;
    exp_instr = '0;
    fetch(32'h0000_0104, 32'h0000_0093, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
